// File: rtl/bit_sparsity_pkg.sv
// ---------------------------------------------------------------------------
// bit_sparsity_pkg
// Shared types for the bit-sparse activation path. The bit converter splits
// an activation into the positions of its set bits ("bit places"). The
// assembler rebuilds the activation from those places. Both blocks use the
// types below so they agree on value and place widths.
//
// Contents:
//   ACT_WIDTH    - activation width in bits (8)
//   act_value_t  - one activation value
//   bit_place_t  - index of one bit inside an activation (0..7)
//   asm_state_e  - assembler accumulation state
//   placeMask()  - one-hot value with only the given bit place set
// ---------------------------------------------------------------------------
package bit_sparsity_pkg;

   localparam int ACT_WIDTH = 8;

   typedef logic [ACT_WIDTH-1:0] act_value_t;
   typedef logic [2:0]           bit_place_t;

   // IDLE means the accumulator holds nothing.
   // ACCUM means a value is partly assembled.
   typedef enum logic {
      ASM_IDLE  = 1'b0,
      ASM_ACCUM = 1'b1
   } asm_state_e;

   // Turn a bit place into the value that has only that bit set.
   function automatic act_value_t placeMask(input bit_place_t place);
      placeMask = act_value_t'(1) << place;
   endfunction

endpackage

// File: rtl/assembler_value_fifo.sv
// ---------------------------------------------------------------------------
// assembler_value_fifo
// Small synchronous FIFO that buffers finished activation values on their
// way from the bit-place assembler to the consumer.
//
// Read and write pointers carry one extra wrap bit. When the address bits
// are equal, the wrap bit tells full apart from empty.
//
// Parameters:
//   DEPTH       - number of entries (power of two, at least 2)
// Ports:
//   clk_i       - clock, rising edge
//   rst_ni      - asynchronous active-low reset, empties the FIFO
//   push_i      - write pushData_i this cycle
//   pushData_i  - value to write
//   pop_i       - drop the head entry this cycle
//   popData_o   - head entry, reads as zero while the FIFO is empty
//   full_o      - all DEPTH entries are occupied
//   empty_o     - no entries are occupied
// ---------------------------------------------------------------------------
module assembler_value_fifo
   import bit_sparsity_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  act_value_t pushData_i,
   input  logic       pop_i,
   output act_value_t popData_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wrPtr_q, wrPtr_d;
   logic [AW:0] rdPtr_q, rdPtr_d;
   act_value_t  mem_q [DEPTH];
   logic        wrEn;
   logic        rdEn;

   // A push into a full FIFO is allowed only when the head leaves in the
   // same cycle, because that frees the slot being written.
   // A pop from an empty FIFO is ignored.
   // With these guards, a bad request cannot corrupt the pointers.
   always_comb begin
      empty_o = (wrPtr_q == rdPtr_q);
      full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
      rdEn    = pop_i && !empty_o;
      wrEn    = push_i && (!full_o || rdEn);
      wrPtr_d = wrPtr_q + {{AW{1'b0}}, wrEn};
      rdPtr_d = rdPtr_q + {{AW{1'b0}}, rdEn};
   end

   // Pointer registers.
   // They wrap naturally because the address part is exactly log2(DEPTH)
   // bits wide, and the extra top bit counts the laps.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage array.
   // It is not reset: the pointers alone decide which entries are live, and
   // an empty FIFO hides whatever the array still contains.
   always_ff @(posedge clk_i) begin
      if (wrEn) begin
         mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
      end
   end

   // The head is forced to zero while empty.
   // This way the consumer never sees stale data, including right after reset.
   always_comb begin
      popData_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];
   end

endmodule

// File: rtl/bit_place_assembler.sv
// ---------------------------------------------------------------------------
// bit_place_assembler
// Rebuilds 8-bit activation values from a stream of bit places.
// - Each beat names one set bit of the current value.
// - The final beat is flagged "last".
// - A value with no set bits arrives as a single "zero" beat.
// Finished values go into an output FIFO (assembler_value_fifo) and are
// handed to the consumer in arrival order with a valid/ready handshake.
//
// Optional feature, enabled by defining BIT_PLACE_DUP_CHECK_EN:
//   A sticky DupErrorOut flag. It rises when a beat repeats a bit place
//   that the value being assembled already holds.
//   Without the macro, DupErrorOut is tied low and no check logic exists.
//
// Parameters:
//   DEPTH            - output FIFO entries (power of two, at least 2)
// Ports:
//   CLK              - clock, rising edge
//   RSTN             - asynchronous active-low reset
//   BitPlaceIn       - bit position of one set bit of the current value
//   BitPlaceLastIn   - this beat completes the current value
//   BitPlaceZeroIn   - the value has no set bits (implies last)
//   BitPlaceValidIn  - a beat is offered
//   BitPlaceReadyOut - the assembler can take a beat this cycle
//   ValueOut         - head of the output FIFO
//   ValueValidOut    - the output FIFO is not empty
//   ValueReadyIn     - the consumer takes the head this cycle
//   DupErrorOut      - sticky duplicate-bit-place error
// ---------------------------------------------------------------------------
module bit_place_assembler
   import bit_sparsity_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  bit_place_t BitPlaceIn,
   input  logic       BitPlaceLastIn,
   input  logic       BitPlaceZeroIn,
   input  logic       BitPlaceValidIn,
   output logic       BitPlaceReadyOut,
   output act_value_t ValueOut,
   output logic       ValueValidOut,
   input  logic       ValueReadyIn,
   output logic       DupErrorOut
);

   asm_state_e state_q;
   act_value_t acc_q;
   logic       readyEn_q;

   logic       fifoFull;
   logic       fifoEmpty;
   logic       fifoPush;
   logic       fifoPop;
   act_value_t fifoHead;

   logic       beatAccept;
   logic       valueDone;
   act_value_t newBit;
   act_value_t mergedValue;

   // Handshake and datapath decode.
   // - Ready looks only at FIFO state and the consumer's pop, never at
   //   BitPlaceValidIn, so no combinational loop forms with the producer.
   // - readyEn_q keeps ready low during reset and until the first clock
   //   edge after reset is released.
   // - A zero beat adds no bit, so the value it pushes is the accumulator
   //   as it stands. From IDLE that value is 8'h00.
   always_comb begin
      fifoPop          = !fifoEmpty && ValueReadyIn;
      BitPlaceReadyOut = readyEn_q && (!fifoFull || fifoPop);
      beatAccept       = BitPlaceValidIn && BitPlaceReadyOut;
      valueDone        = BitPlaceLastIn || BitPlaceZeroIn;
      newBit           = BitPlaceZeroIn ? '0 : placeMask(BitPlaceIn);
      mergedValue      = acc_q | newBit;
      fifoPush         = beatAccept && valueDone;
   end

   // Accumulation state machine.
   // - An accepted non-final beat folds its bit into the accumulator and
   //   moves to ACCUM.
   // - An accepted final or zero beat clears the accumulator and returns to
   //   IDLE. The finished value goes to the FIFO on the same edge.
   // - Reset throws away any partly built value.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= ASM_IDLE;
         acc_q     <= '0;
         readyEn_q <= 1'b0;
      end else begin
         readyEn_q <= 1'b1;
         if (beatAccept) begin
            case (state_q)
               ASM_IDLE: begin
                  if (valueDone) begin
                     state_q <= ASM_IDLE;
                     acc_q   <= '0;
                  end else begin
                     state_q <= ASM_ACCUM;
                     acc_q   <= mergedValue;
                  end
               end
               ASM_ACCUM: begin
                  if (valueDone) begin
                     state_q <= ASM_IDLE;
                     acc_q   <= '0;
                  end else begin
                     state_q <= ASM_ACCUM;
                     acc_q   <= mergedValue;
                  end
               end
               default: begin
                  state_q <= ASM_IDLE;
                  acc_q   <= '0;
               end
            endcase
         end
      end
   end

   // Output buffering.
   // The finished value enters the FIFO on the accepting edge, so it is
   // visible at the output one cycle later.
   assembler_value_fifo #(
      .DEPTH (DEPTH)
   ) u_valueFifo (
      .clk_i      (CLK),
      .rst_ni     (RSTN),
      .push_i     (fifoPush),
      .pushData_i (mergedValue),
      .pop_i      (fifoPop),
      .popData_o  (fifoHead),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty)
   );

   always_comb begin
      ValueOut      = fifoHead;
      ValueValidOut = !fifoEmpty;
   end

`ifdef BIT_PLACE_DUP_CHECK_EN
   logic dupError_q;
   logic dupHit;

   // A duplicate is an accepted non-zero beat whose bit is already held in
   // the accumulator. The value is still built by OR, so only the flag
   // records the problem. Once set, the flag stays high until reset.
   always_comb begin
      dupHit = beatAccept && !BitPlaceZeroIn && (|(acc_q & newBit));
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         dupError_q <= 1'b0;
      end else if (dupHit) begin
         dupError_q <= 1'b1;
      end
   end

   assign DupErrorOut = dupError_q;
`else
   assign DupErrorOut = 1'b0;
`endif

endmodule

// File: tb/tb_bit_place_assembler.sv
// ---------------------------------------------------------------------------
// tb_bit_place_assembler
// Self-checking bench for bit_place_assembler.
// The reference model keeps three things:
// - the partial value as a plain integer sum of powers of two,
// - the output FIFO as a queue,
// - the expected duplicate flag.
// Define BIT_PLACE_DUP_CHECK_EN to match an RTL build that has the check.
// ---------------------------------------------------------------------------
module tb_bit_place_assembler;
   import bit_sparsity_pkg::*;

   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RSTN = 1'b0;
   bit_place_t BitPlaceIn;
   logic       BitPlaceLastIn;
   logic       BitPlaceZeroIn;
   logic       BitPlaceValidIn;
   logic       BitPlaceReadyOut;
   act_value_t ValueOut;
   logic       ValueValidOut;
   logic       ValueReadyIn;
   logic       DupErrorOut;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   int         mAcc = 0;
   logic [7:0] mQ[$];
   bit         mDup = 1'b0;
`ifdef BIT_PLACE_DUP_CHECK_EN
   bit         mDupEn = 1'b1;
   bit         dupExpected = 1'b1;
`else
   bit         mDupEn = 1'b0;
   bit         dupExpected = 1'b0;
`endif

   bit_place_assembler #(.DEPTH(DEPTH)) dut (
      .CLK              (CLK),
      .RSTN             (RSTN),
      .BitPlaceIn       (BitPlaceIn),
      .BitPlaceLastIn   (BitPlaceLastIn),
      .BitPlaceZeroIn   (BitPlaceZeroIn),
      .BitPlaceValidIn  (BitPlaceValidIn),
      .BitPlaceReadyOut (BitPlaceReadyOut),
      .ValueOut         (ValueOut),
      .ValueValidOut    (ValueValidOut),
      .ValueReadyIn     (ValueReadyIn),
      .DupErrorOut      (DupErrorOut)
   );

   always #5 CLK = ~CLK;

   // Expected head of the output: the oldest queued value, or zero when the
   // queue is empty.
   function automatic logic [7:0] modelHead();
      return (mQ.size() > 0) ? mQ[0] : 8'h00;
   endfunction

   // Runs one clock cycle. It is entered and left on a falling edge.
   // - Ready is sampled just after the inputs settle.
   // - The expected ready comes from the model's FIFO occupancy.
   // - On the rising edge the model pops first and then applies the beat,
   //   because a push into a full FIFO relies on the slot freed by the pop.
   task automatic drive(input bit v, input int place, input bit last,
                        input bit zero, input bit popReq,
                        output bit obsReady, output bit expReady);
      int weight;
      BitPlaceValidIn = v;
      BitPlaceIn      = place[2:0];
      BitPlaceLastIn  = last;
      BitPlaceZeroIn  = zero;
      ValueReadyIn    = popReq;
      #1;
      obsReady = BitPlaceReadyOut;
      expReady = (mQ.size() < DEPTH) || (popReq && mQ.size() > 0);
      @(posedge CLK);
      if (popReq && mQ.size() > 0) void'(mQ.pop_front());
      if (v && expReady) begin
         if (zero) begin
            mQ.push_back(8'(mAcc));
            mAcc = 0;
         end else begin
            weight = 2 ** place;
            if (((mAcc / weight) % 2) == 1) mDup = mDup | mDupEn;
            else mAcc = mAcc + weight;
            if (last) begin
               mQ.push_back(8'(mAcc));
               mAcc = 0;
            end
         end
      end
      @(negedge CLK);
      BitPlaceValidIn = 1'b0;
   endtask

   // Asserts reset mid-cycle, then releases it and lets one clock edge pass.
   // The model is cleared to match.
   task automatic applyReset();
      BitPlaceValidIn = 1'b0;
      ValueReadyIn    = 1'b0;
      RSTN            = 1'b0;
      mQ.delete();
      mAcc = 0;
      mDup = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Reset values.
   // Ready must stay low until the first edge after release.
   // A reset taken with queued and partial data must clear everything.
   task automatic test_reset();
      bit obs, exp;
      #1;
      checks++; if (BitPlaceReadyOut !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", BitPlaceReadyOut); end
      checks++; if (ValueValidOut !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ValueValidOut); end
      checks++; if (ValueOut !== 8'h00) begin errors++; $display("FAIL reset_value: got %h expected 00", ValueOut); end
      checks++; if (DupErrorOut !== 1'b0) begin errors++; $display("FAIL reset_dup: got %b expected 0", DupErrorOut); end
      @(negedge CLK);
      RSTN = 1'b1;
      #1;
      checks++; if (BitPlaceReadyOut !== 1'b0) begin errors++; $display("FAIL release_ready_pre_edge: got %b expected 0", BitPlaceReadyOut); end
      @(posedge CLK);
      @(negedge CLK);
      checks++; if (BitPlaceReadyOut !== 1'b1) begin errors++; $display("FAIL release_ready_post_edge: got %b expected 1", BitPlaceReadyOut); end
      drive(1, 5, 1, 0, 0, obs, exp);
      drive(1, 6, 0, 0, 0, obs, exp);
      checks++; if (ValueValidOut !== 1'b1 || ValueOut !== 8'h20) begin errors++; $display("FAIL prereset_head: got %b/%h expected 1/20", ValueValidOut, ValueOut); end
      RSTN = 1'b0;
      #1;
      checks++; if (ValueValidOut !== 1'b0 || ValueOut !== 8'h00 || BitPlaceReadyOut !== 1'b0) begin errors++; $display("FAIL midreset_clear: got v=%b d=%h r=%b expected 0/00/0", ValueValidOut, ValueOut, BitPlaceReadyOut); end
      applyReset();
   endtask

   // Places 0 then 4 (last) must produce 8'h11, visible one cycle after the
   // second beat.
   task automatic test_basic();
      bit obs, exp;
      drive(1, 0, 0, 0, 1, obs, exp);
      checks++; if (ValueValidOut !== 1'b0) begin errors++; $display("FAIL basic_partial_valid: got %b expected 0", ValueValidOut); end
      drive(1, 4, 1, 0, 1, obs, exp);
      checks++; if (ValueValidOut !== 1'b1 || ValueOut !== 8'h11) begin errors++; $display("FAIL basic_value: got %b/%h expected 1/11", ValueValidOut, ValueOut); end
      drive(0, 0, 0, 0, 1, obs, exp);
      checks++; if (ValueValidOut !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b expected 0", ValueValidOut); end
   endtask

   // A lone zero beat gives 00 (the place input is ignored).
   // A lone place 7 last gives 80.
   task automatic test_single();
      bit obs, exp;
      drive(1, 5, 0, 1, 1, obs, exp);
      checks++; if (ValueValidOut !== 1'b1 || ValueOut !== 8'h00) begin errors++; $display("FAIL zero_beat: got %b/%h expected 1/00", ValueValidOut, ValueOut); end
      drive(1, 7, 1, 0, 1, obs, exp);
      checks++; if (ValueValidOut !== 1'b1 || ValueOut !== 8'h80) begin errors++; $display("FAIL place7: got %b/%h expected 1/80", ValueValidOut, ValueOut); end
      drive(0, 0, 0, 0, 1, obs, exp);
   endtask

   // Five last beats with no pops: four are accepted and the fifth is
   // refused. A pop then lets the fifth in, and the order must be preserved.
   task automatic test_full();
      bit obs, exp;
      logic [7:0] want [4];
      want[0] = 8'h02; want[1] = 8'h04; want[2] = 8'h08; want[3] = 8'h10;
      applyReset();
      for (int p = 0; p < 5; p++) begin
         drive(1, p, 1, 0, 0, obs, exp);
         checks++; if (obs !== (p < 4)) begin errors++; $display("FAIL full_ready_beat%0d: got %b expected %b", p, obs, (p < 4)); end
      end
      checks++; if (ValueOut !== 8'h01) begin errors++; $display("FAIL full_head: got %h expected 01", ValueOut); end
      drive(1, 4, 1, 0, 1, obs, exp);
      checks++; if (obs !== 1'b1) begin errors++; $display("FAIL full_ready_with_pop: got %b expected 1", obs); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (ValueValidOut !== 1'b1 || ValueOut !== want[k]) begin errors++; $display("FAIL full_order%0d: got %b/%h expected 1/%h", k, ValueValidOut, ValueOut, want[k]); end
         drive(0, 0, 0, 0, 1, obs, exp);
      end
      checks++; if (ValueValidOut !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", ValueValidOut); end
   endtask

   // With the FIFO full, a pop and a push in the same cycle must both happen.
   // Valid stays high throughout and the order is preserved.
   task automatic test_back_to_back();
      bit obs, exp;
      logic [7:0] want [8];
      want[0] = 8'h80; want[1] = 8'h40; want[2] = 8'h20; want[3] = 8'h10;
      want[4] = 8'h01; want[5] = 8'h02; want[6] = 8'h04; want[7] = 8'h08;
      applyReset();
      for (int p = 7; p > 3; p--) drive(1, p, 1, 0, 0, obs, exp);
      for (int k = 0; k < 4; k++) begin
         checks++; if (ValueValidOut !== 1'b1 || ValueOut !== want[k]) begin errors++; $display("FAIL b2b_head%0d: got %b/%h expected 1/%h", k, ValueValidOut, ValueOut, want[k]); end
         drive(1, k, 1, 0, 1, obs, exp);
         checks++; if (obs !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", k, obs); end
      end
      for (int k = 4; k < 8; k++) begin
         checks++; if (ValueValidOut !== 1'b1 || ValueOut !== want[k]) begin errors++; $display("FAIL b2b_drain%0d: got %b/%h expected 1/%h", k, ValueValidOut, ValueOut, want[k]); end
         drive(0, 0, 0, 0, 1, obs, exp);
      end
      checks++; if (ValueValidOut !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", ValueValidOut); end
   endtask

   // A reset after a non-last place 3 must discard it, so the next value
   // built from place 1 alone is 02.
   task automatic test_reset_mid();
      bit obs, exp;
      applyReset();
      drive(1, 3, 0, 0, 1, obs, exp);
      applyReset();
      drive(1, 1, 1, 0, 1, obs, exp);
      checks++; if (ValueValidOut !== 1'b1 || ValueOut !== 8'h02) begin errors++; $display("FAIL reset_mid_value: got %b/%h expected 1/02", ValueValidOut, ValueOut); end
      drive(0, 0, 0, 0, 1, obs, exp);
   endtask

   // Places 2, 2 (last): the value is 04 either way. The error flag is set
   // and sticky only in a build with the check, and reset clears it.
   task automatic test_dup();
      bit obs, exp;
      applyReset();
      drive(1, 2, 0, 0, 0, obs, exp);
      drive(1, 2, 1, 0, 0, obs, exp);
      checks++; if (ValueOut !== 8'h04) begin errors++; $display("FAIL dup_value: got %h expected 04", ValueOut); end
      checks++; if (DupErrorOut !== dupExpected) begin errors++; $display("FAIL dup_flag: got %b expected %b", DupErrorOut, dupExpected); end
      drive(0, 0, 0, 0, 1, obs, exp);
      drive(1, 6, 1, 0, 1, obs, exp);
      checks++; if (DupErrorOut !== dupExpected) begin errors++; $display("FAIL dup_sticky: got %b expected %b", DupErrorOut, dupExpected); end
      applyReset();
      checks++; if (DupErrorOut !== 1'b0) begin errors++; $display("FAIL dup_cleared: got %b expected 0", DupErrorOut); end
   endtask

   // Random beats and pops compared against the model every cycle.
   // Some stretches have no pops so the FIFO fills up.
   task automatic test_random();
      bit obs, exp, v, last, zero, popReq;
      int place, bad;
      applyReset();
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         v      = ($urandom_range(0, 3) != 0);
         place  = $urandom_range(0, 7);
         last   = ($urandom_range(0, 2) == 0);
         zero   = ($urandom_range(0, 7) == 0);
         popReq = ((i % 50) < 20) ? 1'b0 : 1'($urandom_range(0, 1));
         checks++;
         if (ValueValidOut !== (mQ.size() > 0) || ValueOut !== modelHead() || DupErrorOut !== mDup) begin
            errors++;
            if (bad < 10) $display("FAIL rand_out%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b", i, ValueValidOut, ValueOut, DupErrorOut, (mQ.size() > 0), modelHead(), mDup);
            bad++;
         end
         drive(v, place, last, zero, popReq, obs, exp);
         checks++;
         if (obs !== exp) begin
            errors++;
            if (bad < 10) $display("FAIL rand_ready%0d: got %b expected %b", i, obs, exp);
            bad++;
         end
      end
   endtask

   initial begin
      BitPlaceIn      = '0;
      BitPlaceLastIn  = 1'b0;
      BitPlaceZeroIn  = 1'b0;
      BitPlaceValidIn = 1'b0;
      ValueReadyIn    = 1'b0;
      test_reset();
      test_basic();
      test_single();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_dup();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/bit_place_assembler.md
BIT_PLACE_ASSEMBLER -- requirements
Module: bit_place_assembler

Interface
REQ-001 SHALL have parameter: DEPTH, 4, output value FIFO entries (power of two, >=2).
REQ-002 SHALL have port: CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: RSTN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: BitPlaceIn  input  3  bit position (0..7) of one set bit of the current value.
REQ-005 SHALL have port: BitPlaceLastIn  input  1  beat is the final bit place of the current value.
REQ-006 SHALL have port: BitPlaceZeroIn  input  1  value has no set bits; BitPlaceIn ignored; implies last.
REQ-007 SHALL have port: BitPlaceValidIn  input  1  beat offered.
REQ-008 SHALL have port: BitPlaceReadyOut  output  1  beat accepted when Valid&&Ready at CLK edge.
REQ-009 SHALL have port: ValueOut  output  8  reassembled activation value, head of output FIFO.
REQ-010 SHALL have port: ValueValidOut  output  1  output FIFO not empty.
REQ-011 SHALL have port: ValueReadyIn  input  1  consumer pops head when Valid&&Ready.
REQ-012 SHALL have port: DupErrorOut  output  1  sticky duplicate-bit-place error (see Configuration).

Function
REQ-013 SHALL keep an 8-bit accumulator; each accepted non-zero beat ORs (8'b1 << BitPlaceIn) into it.
REQ-014 SHALL implement states IDLE (accumulator empty) and ACCUM (partial value held); IDLE->ACCUM on accepted non-last beat; ACCUM->IDLE on accepted last or zero beat; otherwise hold.
REQ-015 SHALL, on an accepted last beat, push (accumulator | new bit) into the output FIFO and clear the accumulator in the same edge.
REQ-016 SHALL, on an accepted zero beat, push 8'h00; a zero beat in ACCUM SHALL push the accumulator unchanged and return to IDLE.
REQ-017 SHALL present a pushed value on ValueOut/ValueValidOut one cycle after the accepting edge (latency 1).
REQ-018 SHALL drive BitPlaceReadyOut = 1 when FIFO not full, or when full and a pop occurs this cycle; never combinationally depend on BitPlaceValidIn.
REQ-019 SHALL support simultaneous push and pop at any occupancy including full; occupancy unchanged.
REQ-020 SHALL ignore ValueReadyIn when empty; ValueOut SHALL hold stable while ValueValidOut=1 and not popped.
REQ-021 SHALL wrap read/write pointers modulo DEPTH with an extra bit for full/empty distinction.
REQ-022 SHALL output values in beat-arrival order; no value lost or duplicated.

Reset
REQ-023 SHALL, on RSTN low, asynchronously set state IDLE, accumulator 0, pointers 0, ValueValidOut 0, ValueOut 0, DupErrorOut 0, BitPlaceReadyOut 0 while RSTN low.
REQ-024 SHALL discard any partial value and all FIFO contents on reset mid-operation; BitPlaceReadyOut=1 from first edge after RSTN release.

Configuration
REQ-025 SHALL, with BIT_PLACE_DUP_CHECK_EN defined, set DupErrorOut sticky-high the edge after accepting a beat whose bit is already set in the accumulator; value still assembled by OR; cleared only by reset.
REQ-026 SHALL, without BIT_PLACE_DUP_CHECK_EN, tie DupErrorOut to 0 and include no check logic.

Structure
REQ-027 SHALL take act_value_t (logic [7:0]), bit_place_t (logic [2:0]) and ACT_WIDTH=8 from shared package bit_sparsity_pkg, also used by the bit converter.
REQ-028 SHALL instantiate one sub-module assembler_value_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty) for output buffering.

Verification
REQ-029 SHALL cover: places 0 then 4(last), ValueReadyIn=1 -> ValueOut=8'h11 one cycle after second beat.
REQ-030 SHALL cover: single zero beat -> ValueOut=8'h00; single place 7 last -> 8'h80.
REQ-031 SHALL cover: ValueReadyIn=0, five last beats (places 0..4), DEPTH=4 -> four accepted, ReadyOut=0 on fifth; then pop -> fifth accepted, outputs 01,02,04,08,10 in order.
REQ-032 SHALL cover: FIFO full with simultaneous pop and last-beat push -> both occur, ValueValidOut stays 1, order preserved.
REQ-033 SHALL cover: RSTN pulsed low after place 3 (non-last) -> next places 1 last yield 8'h02, not 8'h0A.
REQ-034 SHALL cover: with BIT_PLACE_DUP_CHECK_EN, places 2,2(last) -> ValueOut=8'h04, DupErrorOut=1 until reset; without macro DupErrorOut=0.
